// File: rtl/led_move_ctrl_if.sv
// Command handshake between the LED move scheduler and the position datapath.
interface led_move_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/led_move_ctrl.sv
// LED move scheduler: turns debounced button levels into HOME/LEFT/RIGHT step
// commands with hold-to-repeat on left/right, and offers them over valid/ready.
module led_move_ctrl #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_left,
    input  logic             btn_right,
    led_move_ctrl_if.master  cmd,
    output logic             repeat_active
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_HOME  = 2'b11;

    logic          prev_up, prev_left, prev_right;
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dir_r, dir_n;          // 0 = left, 1 = right
    logic          valid_r, home_pend;
    logic [1:0]    op_r;

    logic          rise_up, rise_left, rise_right;
    logic          dir_btn, opp_btn, hold_exit;
    logic          iss_home, iss_step;
    logic [1:0]    step_op;
    logic          xfer, pend;

    assign rise_up    = btn_up    & ~prev_up;
    assign rise_left  = btn_left  & ~prev_left;
    assign rise_right = btn_right & ~prev_right;

    assign dir_btn   = dir_r ? btn_right : btn_left;
    assign opp_btn   = dir_r ? btn_left  : btn_right;
    assign hold_exit = ~dir_btn | opp_btn;

    assign xfer = valid_r &  cmd.cmd_ready;
    assign pend = valid_r & ~cmd.cmd_ready;

    // Button history; resets high so a button held through reset never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_up    <= 1'b1;
            prev_left  <= 1'b1;
            prev_right <= 1'b1;
        end else begin
            prev_up    <= btn_up;
            prev_left  <= btn_left;
            prev_right <= btn_right;
        end
    end

    // Next-state logic: press arbitration, hold timing and repeat timing.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dir_n    = dir_r;
        iss_home = 1'b0;
        iss_step = 1'b0;
        step_op  = OP_NONE;
        if (rise_up) begin
            iss_home = 1'b1;
            state_n  = S_IDLE;
            cnt_n    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise_left && !btn_right) begin
                        iss_step = 1'b1;
                        step_op  = OP_LEFT;
                        dir_n    = 1'b0;
                        cnt_n    = '0;
                        state_n  = S_HOLD;
                    end else if (rise_right && !btn_left) begin
                        iss_step = 1'b1;
                        step_op  = OP_RIGHT;
                        dir_n    = 1'b1;
                        cnt_n    = '0;
                        state_n  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_exit) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        iss_step = 1'b1;
                        step_op  = dir_r ? OP_RIGHT : OP_LEFT;
                        cnt_n    = '0;
                        state_n  = S_REPEAT;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_REPEAT: begin
                    if (hold_exit) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                        iss_step = 1'b1;
                        step_op  = dir_r ? OP_RIGHT : OP_LEFT;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // FSM state, hold/repeat counter and active direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir_r <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir_r <= dir_n;
        end
    end

    // Command register: a deferred HOME goes out on the transfer edge of the
    // stalled command; steps arriving during a stall are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            op_r      <= OP_NONE;
            home_pend <= 1'b0;
        end else if (home_pend && xfer) begin
            valid_r   <= 1'b1;
            op_r      <= OP_HOME;
            home_pend <= 1'b0;
        end else if (iss_home) begin
            if (pend) begin
                if (op_r != OP_HOME) begin
                    home_pend <= 1'b1;
                end
            end else begin
                valid_r <= 1'b1;
                op_r    <= OP_HOME;
            end
        end else if (iss_step && !pend) begin
            valid_r <= 1'b1;
            op_r    <= step_op;
        end else if (xfer) begin
            valid_r <= 1'b0;
            op_r    <= OP_NONE;
        end
    end

    assign cmd.cmd_valid = valid_r;
    assign cmd.cmd_op    = op_r;
    assign repeat_active = (state == S_REPEAT);

endmodule

// File: tb/tb_led_move_ctrl.sv
// Randomized bench for led_move_ctrl, checked against a press/age reference model.
module tb_led_move_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic repeat_active;

    int total = 0;
    int bad   = 0;

    led_move_ctrl_if bus ();

    led_move_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .cmd           (bus),
        .repeat_active (repeat_active)
    );

    always #5 clk = ~clk;

    // Reference model: a direction press is "active" from its qualifying edge;
    // its age in cycles decides when steps fall due.
    logic       m_pu, m_pl, m_pr;
    logic       m_act, m_dir;
    int         m_age;
    logic       m_valid, m_hp;
    logic [1:0] m_op;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pu = 1'b1; m_pl = 1'b1; m_pr = 1'b1;
        m_act = 1'b0; m_dir = 1'b0; m_age = 0;
        m_valid = 1'b0; m_hp = 1'b0; m_op = 2'b00;
    endtask

    task automatic model_step();
        logic ru, rl, rr, held, opp, xfer, pend;
        int   iss;
        ru = btn_up & ~m_pu;
        rl = btn_left & ~m_pl;
        rr = btn_right & ~m_pr;
        iss = 0;
        if (ru) begin
            iss = 3;
            m_act = 1'b0;
        end else if (m_act) begin
            held = m_dir ? btn_right : btn_left;
            opp  = m_dir ? btn_left : btn_right;
            if (!held || opp) begin
                m_act = 1'b0;
            end else begin
                m_age++;
                if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
                    iss = m_dir ? 2 : 1;
            end
        end else if (rl && !btn_right) begin
            m_act = 1'b1; m_dir = 1'b0; m_age = 0; iss = 1;
        end else if (rr && !btn_left) begin
            m_act = 1'b1; m_dir = 1'b1; m_age = 0; iss = 2;
        end
        xfer = m_valid & bus.cmd_ready;
        pend = m_valid & ~bus.cmd_ready;
        if (m_hp && xfer) begin
            m_valid = 1'b1; m_op = 2'b11; m_hp = 1'b0;
        end else if (iss == 3) begin
            if (pend) begin
                if (m_op != 2'b11) m_hp = 1'b1;
            end else begin
                m_valid = 1'b1; m_op = 2'b11;
            end
        end else if (iss != 0 && !pend) begin
            m_valid = 1'b1; m_op = 2'(iss);
        end else if (xfer) begin
            m_valid = 1'b0; m_op = 2'b00;
        end
        m_pu = btn_up; m_pl = btn_left; m_pr = btn_right;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".valid"}, {3'b0, bus.cmd_valid}, {3'b0, m_valid});
        check({where, ".op"}, {2'b0, bus.cmd_op}, {2'b0, m_op});
        check({where, ".rep"}, {3'b0, repeat_active}, {3'b0, m_act && m_age >= HOLD});
    endtask

    int t_l, t_r, t_u, t_rdy, rdy_mode;

    initial begin
        bus.cmd_ready = 1'b1;
        model_reset();
        t_l = 0; t_r = 0; t_u = 20; t_rdy = 0; rdy_mode = 0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        // Left held through reset release must not fire.
        btn_left = 1'b1;
        t_l = 15;
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) rdy_mode = int'($urandom_range(0, 2));

            if (t_l == 0) begin
                btn_left = ~btn_left;
                t_l = btn_left ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 12));
            end else t_l--;
            if (t_r == 0) begin
                btn_right = ~btn_right;
                t_r = btn_right ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 12));
            end else t_r--;
            if (!btn_left && !btn_right && $urandom_range(0, 30) == 0) begin
                btn_left = 1'b1; btn_right = 1'b1;
                t_l = int'($urandom_range(1, 20)); t_r = t_l + int'($urandom_range(0, 10));
            end
            if (t_u == 0) begin
                btn_up = ~btn_up;
                t_u = btn_up ? int'($urandom_range(0, 1)) : int'($urandom_range(10, 80));
            end else t_u--;

            case (rdy_mode)
                0: bus.cmd_ready = 1'b1;
                1: bus.cmd_ready = $urandom_range(0, 1) == 1;
                default: begin
                    if (t_rdy == 0) begin
                        bus.cmd_ready = ~bus.cmd_ready;
                        t_rdy = int'($urandom_range(0, 7));
                    end else t_rdy--;
                end
            endcase

            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end

            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs("run");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
